// File: rtl/leb128_decoder.sv
// LEB128 immediate decoder for the fetch stream: gathers 7-bit groups into a 64-bit value,
// then holds the result (or an error code) until the execute stage takes it.
module leb128_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic        is_signed,
  input  logic        is_64,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_value,
  output logic [3:0]  out_len,
  output logic [1:0]  error
);

  // state | meaning
  // ACCUM | accepting bytes, building acc (in_ready=1, out_valid=0)
  // HOLD  | result/error presented until out_ready (in_ready=0, out_valid=1)
  typedef enum logic {ACCUM, HOLD} state_t;

  state_t      state;
  logic [63:0] acc;
  logic [3:0]  count;
  logic        mode_signed;
  logic        mode_64;

  logic        sgn;
  logic        w64;
  logic [3:0]  cnt_n;
  logic [3:0]  max_len;
  logic        last;
  logic [6:0]  sh_cur;
  logic [6:0]  sh_nxt;
  logic [63:0] acc_n;
  logic [63:0] ext;
  logic        pad_ok;

  // The first byte of a value uses the live mode inputs; later bytes use the latched copy.
  always_comb begin
    sgn     = (count == 4'd0) ? is_signed : mode_signed;
    w64     = (count == 4'd0) ? is_64 : mode_64;
    cnt_n   = count + 4'd1;
    max_len = w64 ? 4'd10 : 4'd5;
    last    = (cnt_n == max_len);
    sh_cur  = {3'b000, count} * 7'd7;
    sh_nxt  = {3'b000, cnt_n} * 7'd7;
    acc_n   = acc | ({57'b0, in_byte[6:0]} << sh_cur);
    ext     = acc_n;
    if (sgn && in_byte[6] && (sh_nxt < 7'd64))
      ext = acc_n | ({64{1'b1}} << sh_nxt);
    if (!w64)
      ext = sgn ? {{32{ext[31]}}, ext[31:0]} : {32'b0, ext[31:0]};
    pad_ok = 1'b1;
    if (last) begin
      if (w64)
        pad_ok = sgn ? ((in_byte[6:0] == 7'h00) || (in_byte[6:0] == 7'h7f))
                     : (in_byte[6:1] == 6'h00);
      else
        pad_ok = sgn ? ((in_byte[6:3] == 4'h0) || (in_byte[6:3] == 4'hf))
                     : (in_byte[6:4] == 3'h0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ACCUM;
      acc         <= 64'd0;
      count       <= 4'd0;
      mode_signed <= 1'b0;
      mode_64     <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_value   <= 64'd0;
      out_len     <= 4'd0;
      error       <= 2'd0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (count == 4'd0) begin
              mode_signed <= is_signed;
              mode_64     <= is_64;
            end
            if (in_byte[7] && !last) begin
              acc   <= acc_n;
              count <= cnt_n;
            end else begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_len   <= cnt_n;
              acc       <= 64'd0;
              count     <= 4'd0;
              if (in_byte[7]) begin
                error     <= 2'd1;
                out_value <= 64'd0;
              end else if (!pad_ok) begin
                error     <= 2'd2;
                out_value <= 64'd0;
              end else begin
                error     <= 2'd0;
                out_value <= ext;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
